dpsram_port_arbiter: RTL and testbench

Shares one DPSRAM port among NREQ requesters (servo-table loader, gait sequencer, telemetry readback) using round-robin arbitration. Registers the winning request onto the SRAM port and routes read data back to the originating requester after the fixed RAM read latency. It sits between the requester logic and the SRAM port, driving address, data, enable, write-enable, clock and reset.

---
 rtl/dpsram_arb_pkg.sv | 13 +
 rtl/dpsram_port_arbiter_rr_pick.sv | 46 ++++
 rtl/dpsram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_dpsram_port_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dpsram_arb_pkg.sv
// Shared types for the DPSRAM port arbiter: requester id and read-return tag.
package dpsram_arb_pkg;

    localparam int MAX_NREQ = 8;

    typedef logic [$clog2(MAX_NREQ)-1:0] req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/dpsram_port_arbiter_rr_pick.sv
// Combinational one-hot pick: the first set request after position ptr, wrapping modulo NREQ.
module rr_pick
    import dpsram_arb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic [NREQ-1:0] req,
    input  req_id_t         ptr,
    output logic [NREQ-1:0] grant,
    output req_id_t         win_id
);

    int   rank;
    int   best;
    int   win;
    logic found;

    // Rank each requester by its distance past ptr; the smallest valid rank wins.
    always_comb begin
        rank  = 0;
        best  = NREQ;
        win   = 0;
        found = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            rank = i - int'(ptr) - 1;
            if (rank < 0) begin
                rank = rank + NREQ;
            end
            if (req[i] && (rank < best)) begin
                best  = rank;
                win   = i;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            grant[i] = found && (win == i);
        end
    end

    assign win_id = req_id_t'(win);

endmodule

// File: rtl/dpsram_port_arbiter.sv
// Shares one DPSRAM port among NREQ requesters and routes read data back by tag.
// Define DPSRAM_ARB_RR_EN for round-robin arbitration; otherwise fixed lowest-index priority.
module dpsram_port_arbiter
    import dpsram_arb_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 32,
    parameter int NREQ   = 2,
    parameter int RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*AWIDTH-1:0] req_addr,
    input  logic [NREQ*DWIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [DWIDTH-1:0]      rsp_rdata,
    output logic                   sram_clk,
    output logic                   sram_rst,
    output logic                   sram_en,
    output logic                   sram_we,
    output logic [AWIDTH-1:0]      sram_addr,
    output logic [DWIDTH-1:0]      sram_din,
    input  logic [DWIDTH-1:0]      sram_dout
);

    logic [NREQ-1:0]   grant;
    req_id_t           win_id;
    req_id_t           pick_ptr;
    logic              win_we;
    logic [AWIDTH-1:0] win_addr;
    logic [DWIDTH-1:0] win_din;

    logic              sram_en_reg;
    logic              sram_we_reg;
    logic [AWIDTH-1:0] sram_addr_reg;
    logic [DWIDTH-1:0] sram_din_reg;
    req_id_t           issue_id_reg;
    rd_tag_t           tag_reg [RD_LAT];
    rd_tag_t           tag_next;
    rd_tag_t           tag_out;

    assign sram_clk = clk;
    assign sram_rst = rst;

`ifdef DPSRAM_ARB_RR_EN
    req_id_t last_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_reg <= req_id_t'(NREQ - 1);
        end else if (|req_ready) begin
            last_reg <= win_id;
        end
    end

    assign pick_ptr = last_reg;
`else
    // Pointer pinned at NREQ-1 makes requester 0 always the first candidate.
    assign pick_ptr = req_id_t'(NREQ - 1);
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (req_valid),
        .ptr    (pick_ptr),
        .grant  (grant),
        .win_id (win_id)
    );

    assign req_ready = rst ? '0 : grant;

    always_comb begin
        win_we   = 1'b0;
        win_addr = '0;
        win_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                win_we   = req_we[i];
                win_addr = req_addr[i*AWIDTH +: AWIDTH];
                win_din  = req_wdata[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Address and data hold their last value between grants; only enable/write drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sram_en_reg   <= 1'b0;
            sram_we_reg   <= 1'b0;
            sram_addr_reg <= '0;
            sram_din_reg  <= '0;
            issue_id_reg  <= '0;
        end else if (|req_ready) begin
            sram_en_reg   <= 1'b1;
            sram_we_reg   <= win_we;
            sram_addr_reg <= win_addr;
            sram_din_reg  <= win_din;
            issue_id_reg  <= win_id;
        end else begin
            sram_en_reg   <= 1'b0;
            sram_we_reg   <= 1'b0;
        end
    end

    assign sram_en   = sram_en_reg;
    assign sram_we   = sram_we_reg;
    assign sram_addr = sram_addr_reg;
    assign sram_din  = sram_din_reg;

    assign tag_next.valid = sram_en_reg & ~sram_we_reg;
    assign tag_next.id    = issue_id_reg;

    // Tag enters on the same edge the SRAM samples the read, so it exits with valid dout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                tag_reg[i] <= '0;
            end
        end else begin
            tag_reg[0] <= tag_next;
            for (int i = 1; i < RD_LAT; i++) begin
                tag_reg[i] <= tag_reg[i-1];
            end
        end
    end

    assign tag_out = tag_reg[RD_LAT-1];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
            assign rsp_valid[gi] = tag_out.valid && (tag_out.id == req_id_t'(gi));
        end
    endgenerate

    assign rsp_rdata = sram_dout;

endmodule

// File: tb/tb_dpsram_port_arbiter.sv
// Directed bench for dpsram_port_arbiter: RD_LAT=1 instance plus an RD_LAT=2 instance.
module tb_dpsram_port_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;

    logic [1:0]  req_ready1, rsp_valid1;
    logic [31:0] rsp_rdata1, sram_addr1, sram_din1, sram_dout1;
    logic        sram_clk1, sram_rst1, sram_en1, sram_we1;

    logic [1:0]  req_ready2, rsp_valid2;
    logic [31:0] rsp_rdata2, sram_addr2, sram_din2, sram_dout2;
    logic        sram_clk2, sram_rst2, sram_en2, sram_we2;

    int tests = 0;
    int fails = 0;
    int cnt0  = 0;
    logic [1:0] exp_grant;

    dpsram_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .NREQ(2), .RD_LAT(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready1),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1),
        .sram_clk(sram_clk1), .sram_rst(sram_rst1), .sram_en(sram_en1), .sram_we(sram_we1),
        .sram_addr(sram_addr1), .sram_din(sram_din1), .sram_dout(sram_dout1)
    );

    dpsram_port_arbiter #(.DWIDTH(32), .AWIDTH(32), .NREQ(2), .RD_LAT(2)) u_dut2 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready2),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid2), .rsp_rdata(rsp_rdata2),
        .sram_clk(sram_clk2), .sram_rst(sram_rst2), .sram_en(sram_en2), .sram_we(sram_we2),
        .sram_addr(sram_addr2), .sram_din(sram_din2), .sram_dout(sram_dout2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM models: latency 1 and latency 2, preloaded while reset is high.
    logic [31:0] mem1 [256];
    logic [31:0] rd1;
    logic [31:0] mem2 [256];
    logic [31:0] rd2a, rd2b;

    always @(posedge clk) begin
        if (rst) begin
            mem1[8'h40] <= 32'hDEADBEEF;
        end else if (sram_en1) begin
            if (sram_we1) mem1[sram_addr1[7:0]] <= sram_din1;
            else          rd1 <= mem1[sram_addr1[7:0]];
        end
    end
    assign sram_dout1 = rd1;

    always @(posedge clk) begin
        if (rst) begin
            mem2[8'h20] <= 32'hA1A1A1A1;
            mem2[8'h24] <= 32'hB2B2B2B2;
            mem2[8'h28] <= 32'hC3C3C3C3;
        end else if (sram_en2 && sram_we2) begin
            mem2[sram_addr2[7:0]] <= sram_din2;
        end
        if (sram_en2 && !sram_we2) rd2a <= mem2[sram_addr2[7:0]];
        rd2b <= rd2a;
    end
    assign sram_dout2 = rd2b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("[TB] check %s observed %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 2'b11;
        req_we    = 2'b00;
        req_addr  = {32'h40, 32'h00};
        req_wdata = '0;

        // Reset state with both requesters asking
        @(negedge clk);
        @(negedge clk);
        chk("rst_ready", {30'd0, req_ready1}, 32'h0);
        chk("rst_en", {31'd0, sram_en1}, 32'h0);
        chk("rst_we", {31'd0, sram_we1}, 32'h0);
        chk("rst_rsp", {30'd0, rsp_valid1}, 32'h0);
        chk("rst_addr", sram_addr1, 32'h0);
        chk("rst_din", sram_din1, 32'h0);
        rst = 1'b0;
        #1;
        chk("first_grant", {30'd0, req_ready1}, 32'h1);
        req_valid = 2'b00;

        // Single read by requester 1
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("rd_ready", {30'd0, req_ready1}, 32'h2);
        @(negedge clk);
        chk("rd_en", {31'd0, sram_en1}, 32'h1);
        chk("rd_addr", sram_addr1, 32'h40);
        chk("rd_we", {31'd0, sram_we1}, 32'h0);
        chk("rd_rsp_early", {30'd0, rsp_valid1}, 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rd_rsp", {30'd0, rsp_valid1}, 32'h2);
        chk("rd_data", rsp_rdata1, 32'hDEADBEEF);

        // Contention for 8 cycles
        @(negedge clk);
        req_valid = 2'b11;
        for (int k = 0; k < 8; k++) begin
            #1;
`ifdef DPSRAM_ARB_RR_EN
            exp_grant = (k % 2 == 0) ? 2'b01 : 2'b10;
`else
            exp_grant = 2'b01;
`endif
            chk($sformatf("cont_grant%0d", k), {30'd0, req_ready1}, {30'd0, exp_grant});
            if (req_ready1 == 2'b01) cnt0++;
            @(negedge clk);
        end
        req_valid = 2'b00;
`ifdef DPSRAM_ARB_RR_EN
        chk("cont_cnt0", cnt0, 32'd4);
`else
        chk("cont_cnt0", cnt0, 32'd8);
`endif
        repeat (3) @(negedge clk);

        // Write then read the same address by requester 0
        req_valid = 2'b01;
        req_we    = 2'b01;
        req_addr  = {32'h40, 32'h10};
        req_wdata = {32'h0, 32'h1234};
        #1;
        chk("wr_ready", {30'd0, req_ready1}, 32'h1);
        @(negedge clk);
        chk("wr_en", {31'd0, sram_en1}, 32'h1);
        chk("wr_we", {31'd0, sram_we1}, 32'h1);
        chk("wr_addr", sram_addr1, 32'h10);
        chk("wr_din", sram_din1, 32'h1234);
        req_we = 2'b00;
        #1;
        chk("rdb_ready", {30'd0, req_ready1}, 32'h1);
        @(negedge clk);
        chk("rdb_en", {31'd0, sram_en1}, 32'h1);
        chk("rdb_we", {31'd0, sram_we1}, 32'h0);
        chk("wr_no_rsp", {30'd0, rsp_valid1}, 32'h0);
        req_valid = 2'b00;
        @(negedge clk);
        chk("rdb_rsp", {30'd0, rsp_valid1}, 32'h1);
        chk("rdb_data", rsp_rdata1, 32'h1234);
        chk("idle_en", {31'd0, sram_en1}, 32'h0);
        chk("idle_we", {31'd0, sram_we1}, 32'h0);

        // Pipelined reads 0,1,0 on the RD_LAT=2 instance
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {32'h24, 32'h20};
        @(negedge clk);
        req_valid = 2'b10;
        @(negedge clk);
        req_valid = 2'b01;
        req_addr  = {32'h24, 32'h28};
        chk("pipe_not_early", {30'd0, rsp_valid2}, 32'h0);
        @(negedge clk);
        req_valid = 2'b00;
        chk("pipe_rsp0", {30'd0, rsp_valid2}, 32'h1);
        chk("pipe_data0", rsp_rdata2, 32'hA1A1A1A1);
        @(negedge clk);
        chk("pipe_rsp1", {30'd0, rsp_valid2}, 32'h2);
        chk("pipe_data1", rsp_rdata2, 32'hB2B2B2B2);
        @(negedge clk);
        chk("pipe_rsp2", {30'd0, rsp_valid2}, 32'h1);
        chk("pipe_data2", rsp_rdata2, 32'hC3C3C3C3);
        @(negedge clk);
        chk("pipe_done", {30'd0, rsp_valid2}, 32'h0);

        // Reset one cycle after a read grant
        req_valid = 2'b10;
        req_addr  = {32'h40, 32'h00};
        #1;
        chk("mid_ready", {30'd0, req_ready1}, 32'h2);
        @(negedge clk);
        rst       = 1'b1;
        req_valid = 2'b00;
        #1;
        chk("mid_en", {31'd0, sram_en1}, 32'h0);
        chk("mid_rsp_a", {30'd0, rsp_valid1}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rsp_b", {30'd0, rsp_valid1}, 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("mid_rsp_after%0d", k), {30'd0, rsp_valid1}, 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
